reorder_buffer: RTL and testbench

In-order retirement buffer for the dual-issue out-of-order core. Sits downstream of dispatch and beside the reservation station: it allocates ROB tags for two decoded instructions per cycle, supplies the tag base that the reservation station stamps into its rows, and collects results from the three functional units. It retires completed entries strictly in program order, up to two per cycle, and reports each retirement to the rename/free-list and architectural-commit logic.

---
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch allocation, three-FU completion, in-order commit.
// ROB_DUAL_RETIRE_EN enables a second retirement slot per cycle; otherwise only slot 0 retires.
module reorder_buffer #(
  parameter int ROB_DEPTH = 64,
  localparam int IW = $clog2(ROB_DEPTH),
  localparam int CW = IW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr1_valid,
  input  logic [IW-1:0]         instr1_p_rd,
  input  logic [IW-1:0]         instr1_old_p_rd,
  input  logic [4:0]            instr1_arch_rd,
  input  logic                  instr2_valid,
  input  logic [IW-1:0]         instr2_p_rd,
  input  logic [IW-1:0]         instr2_old_p_rd,
  input  logic [4:0]            instr2_arch_rd,
  output logic [IW-1:0]         next_robrow,
  output logic                  dispatch_stall,
  input  logic [2:0]            fu_done,
  input  logic [2:0][IW-1:0]    fu_rob_tag,
  input  logic [2:0][31:0]      fu_result,
  output logic [1:0]            commit_valid,
  output logic [1:0][IW-1:0]    commit_p_rd,
  output logic [1:0][IW-1:0]    commit_old_p_rd,
  output logic [1:0][4:0]       commit_arch_rd,
  output logic [1:0][31:0]      commit_data,
  output logic                  rob_empty
);
`ifdef ROB_DUAL_RETIRE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [ROB_DEPTH-1:0]          valid_q, valid_d, done_q, done_d;
  logic [ROB_DEPTH-1:0][IW-1:0]  p_rd_q, p_rd_d, old_p_rd_q, old_p_rd_d;
  logic [ROB_DEPTH-1:0][4:0]     arch_rd_q, arch_rd_d;
  logic [ROB_DEPTH-1:0][31:0]    data_q, data_d;
  logic [1:0]                    commit_valid_q, commit_valid_d;
  logic [1:0][IW-1:0]            commit_p_rd_q, commit_p_rd_d, commit_old_p_rd_q, commit_old_p_rd_d;
  logic [1:0][4:0]               commit_arch_rd_q, commit_arch_rd_d;
  logic [1:0][31:0]              commit_data_q, commit_data_d;
  logic stall, alloc1, alloc2, ret0, ret1;
  logic [IW-1:0] tail1, head1;

  always_comb begin
    // Stall looks only at registered count; same-cycle retirement does not free a slot.
    stall  = count_q > CW'(ROB_DEPTH - 2);
    alloc1 = instr1_valid && !stall;
    alloc2 = alloc1 && instr2_valid;
    tail1  = tail_q + IW'(1);
    head1  = head_q + IW'(1);
    ret0   = valid_q[head_q] && done_q[head_q];
    ret1   = DUAL && ret0 && valid_q[head1] && done_q[head1];

    valid_d    = valid_q;
    done_d     = done_q;
    p_rd_d     = p_rd_q;
    old_p_rd_d = old_p_rd_q;
    arch_rd_d  = arch_rd_q;
    data_d     = data_q;

    // Ascending loop order lets the higher FU index win on a tag collision.
    for (int k = 0; k < 3; k++) begin
      if (fu_done[k] && valid_q[fu_rob_tag[k]]) begin
        done_d[fu_rob_tag[k]] = 1'b1;
        data_d[fu_rob_tag[k]] = fu_result[k];
      end
    end

    if (ret0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (ret1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end

    if (alloc1) begin
      valid_d[tail_q]    = 1'b1;
      done_d[tail_q]     = 1'b0;
      p_rd_d[tail_q]     = instr1_p_rd;
      old_p_rd_d[tail_q] = instr1_old_p_rd;
      arch_rd_d[tail_q]  = instr1_arch_rd;
    end
    if (alloc2) begin
      valid_d[tail1]    = 1'b1;
      done_d[tail1]     = 1'b0;
      p_rd_d[tail1]     = instr2_p_rd;
      old_p_rd_d[tail1] = instr2_old_p_rd;
      arch_rd_d[tail1]  = instr2_arch_rd;
    end

    tail_d  = tail_q + IW'(alloc1) + IW'(alloc2);
    head_d  = head_q + IW'(ret0) + IW'(ret1);
    count_d = count_q + CW'(alloc1) + CW'(alloc2) - CW'(ret0) - CW'(ret1);

    commit_valid_d       = {ret1, ret0};
    commit_p_rd_d[0]     = ret0 ? p_rd_q[head_q]     : '0;
    commit_old_p_rd_d[0] = ret0 ? old_p_rd_q[head_q] : '0;
    commit_arch_rd_d[0]  = ret0 ? arch_rd_q[head_q]  : '0;
    commit_data_d[0]     = ret0 ? data_q[head_q]     : '0;
    commit_p_rd_d[1]     = ret1 ? p_rd_q[head1]      : '0;
    commit_old_p_rd_d[1] = ret1 ? old_p_rd_q[head1]  : '0;
    commit_arch_rd_d[1]  = ret1 ? arch_rd_q[head1]   : '0;
    commit_data_d[1]     = ret1 ? data_q[head1]      : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      valid_q           <= '0;
      done_q            <= '0;
      p_rd_q            <= '0;
      old_p_rd_q        <= '0;
      arch_rd_q         <= '0;
      data_q            <= '0;
      commit_valid_q    <= '0;
      commit_p_rd_q     <= '0;
      commit_old_p_rd_q <= '0;
      commit_arch_rd_q  <= '0;
      commit_data_q     <= '0;
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      valid_q           <= valid_d;
      done_q            <= done_d;
      p_rd_q            <= p_rd_d;
      old_p_rd_q        <= old_p_rd_d;
      arch_rd_q         <= arch_rd_d;
      data_q            <= data_d;
      commit_valid_q    <= commit_valid_d;
      commit_p_rd_q     <= commit_p_rd_d;
      commit_old_p_rd_q <= commit_old_p_rd_d;
      commit_arch_rd_q  <= commit_arch_rd_d;
      commit_data_q     <= commit_data_d;
    end
  end

  assign next_robrow     = tail_q;
  assign dispatch_stall  = stall;
  assign rob_empty       = (count_q == '0);
  assign commit_valid    = commit_valid_q;
  assign commit_p_rd     = commit_p_rd_q;
  assign commit_old_p_rd = commit_old_p_rd_q;
  assign commit_arch_rd  = commit_arch_rd_q;
  assign commit_data     = commit_data_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, completion ordering, full/stall, wrap, async reset.
module tb_reorder_buffer;
  logic            clk = 1'b0;
  logic            rst_n;
  logic            instr1_valid, instr2_valid;
  logic [5:0]      instr1_p_rd, instr1_old_p_rd, instr2_p_rd, instr2_old_p_rd;
  logic [4:0]      instr1_arch_rd, instr2_arch_rd;
  logic [5:0]      next_robrow;
  logic            dispatch_stall;
  logic [2:0]      fu_done;
  logic [2:0][5:0] fu_rob_tag;
  logic [2:0][31:0] fu_result;
  logic [1:0]      commit_valid;
  logic [1:0][5:0] commit_p_rd, commit_old_p_rd;
  logic [1:0][4:0] commit_arch_rd;
  logic [1:0][31:0] commit_data;
  logic            rob_empty;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .instr1_valid(instr1_valid), .instr1_p_rd(instr1_p_rd),
    .instr1_old_p_rd(instr1_old_p_rd), .instr1_arch_rd(instr1_arch_rd),
    .instr2_valid(instr2_valid), .instr2_p_rd(instr2_p_rd),
    .instr2_old_p_rd(instr2_old_p_rd), .instr2_arch_rd(instr2_arch_rd),
    .next_robrow(next_robrow), .dispatch_stall(dispatch_stall),
    .fu_done(fu_done), .fu_rob_tag(fu_rob_tag), .fu_result(fu_result),
    .commit_valid(commit_valid), .commit_p_rd(commit_p_rd),
    .commit_old_p_rd(commit_old_p_rd), .commit_arch_rd(commit_arch_rd),
    .commit_data(commit_data), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr1_valid = 0; instr2_valid = 0;
    instr1_p_rd = 0; instr1_old_p_rd = 0; instr1_arch_rd = 0;
    instr2_p_rd = 0; instr2_old_p_rd = 0; instr2_arch_rd = 0;
    fu_done = 0; fu_rob_tag = '0; fu_result = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic disp2(input logic [5:0] t);
    instr1_valid = 1; instr1_p_rd = t + 6'd1; instr1_old_p_rd = t + 6'd2; instr1_arch_rd = t[4:0];
    instr2_valid = 1; instr2_p_rd = t + 6'd2; instr2_old_p_rd = t + 6'd3; instr2_arch_rd = t[4:0] + 5'd1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_cv got %b exp 00", commit_valid); end
    checks++; if (next_robrow !== 6'd0) begin errors++; $display("FAIL reset_robrow got %0d exp 0", next_robrow); end
    checks++; if (dispatch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", dispatch_stall); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", rob_empty); end
    checks++; if (commit_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", commit_data); end
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    instr1_valid = 1; instr1_p_rd = 5; instr1_old_p_rd = 12; instr1_arch_rd = 3;
    tick(); idle();
    checks++; if (next_robrow !== 6'd1) begin errors++; $display("FAIL single_robrow got %0d exp 1", next_robrow); end
    checks++; if (rob_empty !== 1'b0) begin errors++; $display("FAIL single_nonempty got %b exp 0", rob_empty); end
    fu_done = 3'b001; fu_rob_tag[0] = 0; fu_result[0] = 32'hDEADBEEF;
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL single_early got %b exp 00", commit_valid); end
    tick();
    checks++; if (commit_valid !== 2'b01) begin errors++; $display("FAIL single_cv got %b exp 01", commit_valid); end
    checks++; if (commit_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", commit_data[0]); end
    checks++; if (commit_old_p_rd[0] !== 6'd12) begin errors++; $display("FAIL single_old got %0d exp 12", commit_old_p_rd[0]); end
    checks++; if (commit_p_rd[0] !== 6'd5 || commit_arch_rd[0] !== 5'd3) begin errors++; $display("FAIL single_prd got %0d/%0d exp 5/3", commit_p_rd[0], commit_arch_rd[0]); end
    tick();
    checks++; if (commit_valid !== 2'b00 || commit_data[0] !== 32'd0) begin errors++; $display("FAIL single_hold got %b/%h exp 00/0", commit_valid, commit_data[0]); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b exp 1", rob_empty); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    disp2(6'd0);
    tick(); idle();
    fu_done = 3'b010; fu_rob_tag[1] = 1; fu_result[1] = 32'h1111;
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait1 got %b exp 00", commit_valid); end
    fu_done = 3'b001; fu_rob_tag[0] = 0; fu_result[0] = 32'h0000_AAAA;
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL ooo_wait2 got %b exp 00", commit_valid); end
    tick();
`ifdef ROB_DUAL_RETIRE_EN
    checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL ooo_cv got %b exp 11", commit_valid); end
    checks++; if (commit_data[0] !== 32'h0000_AAAA || commit_data[1] !== 32'h1111) begin errors++; $display("FAIL ooo_data got %h/%h exp aaaa/1111", commit_data[0], commit_data[1]); end
    checks++; if (commit_p_rd[1] !== 6'd2 || commit_old_p_rd[1] !== 6'd3) begin errors++; $display("FAIL ooo_fields1 got %0d/%0d exp 2/3", commit_p_rd[1], commit_old_p_rd[1]); end
`else
    checks++; if (commit_valid !== 2'b01 || commit_data[0] !== 32'h0000_AAAA) begin errors++; $display("FAIL ooo_first got %b/%h exp 01/aaaa", commit_valid, commit_data[0]); end
    checks++; if (commit_data[1] !== 32'd0 || commit_p_rd[1] !== 6'd0) begin errors++; $display("FAIL ooo_slot1_zero got %h/%0d exp 0/0", commit_data[1], commit_p_rd[1]); end
    tick();
    checks++; if (commit_valid !== 2'b01 || commit_data[0] !== 32'h1111) begin errors++; $display("FAIL ooo_second got %b/%h exp 01/1111", commit_valid, commit_data[0]); end
    checks++; if (commit_p_rd[0] !== 6'd2 || commit_old_p_rd[0] !== 6'd3) begin errors++; $display("FAIL ooo_fields1 got %0d/%0d exp 2/3", commit_p_rd[0], commit_old_p_rd[0]); end
`endif
    tick();
    checks++; if (commit_valid !== 2'b00 || rob_empty !== 1'b1) begin errors++; $display("FAIL ooo_drain got %b/%b exp 00/1", commit_valid, rob_empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      disp2(6'(2 * i));
      tick();
    end
    checks++; if (dispatch_stall !== 1'b0 || next_robrow !== 6'd62) begin errors++; $display("FAIL full_62 got %b/%0d exp 0/62", dispatch_stall, next_robrow); end
    disp2(6'd62);
    tick();
    checks++; if (dispatch_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", dispatch_stall); end
    checks++; if (next_robrow !== 6'd0) begin errors++; $display("FAIL full_robrow got %0d exp 0", next_robrow); end
    tick();
    checks++; if (next_robrow !== 6'd0 || dispatch_stall !== 1'b1) begin errors++; $display("FAIL full_ignored got %0d/%b exp 0/1", next_robrow, dispatch_stall); end
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      disp2(6'(2 * i));
      tick(); idle();
      fu_done = 3'b011; fu_rob_tag[0] = 6'(2 * i); fu_rob_tag[1] = 6'(2 * i + 1);
      tick(); idle();
    end
    repeat (70) tick();
    checks++; if (rob_empty !== 1'b1 || next_robrow !== 6'd62) begin errors++; $display("FAIL wrap_pre got %b/%0d exp 1/62", rob_empty, next_robrow); end
    instr1_valid = 1; instr1_p_rd = 40; instr1_old_p_rd = 41; instr1_arch_rd = 20;
    tick(); idle();
    checks++; if (next_robrow !== 6'd63) begin errors++; $display("FAIL wrap_63 got %0d exp 63", next_robrow); end
    instr1_valid = 1; instr1_p_rd = 50; instr1_old_p_rd = 51; instr1_arch_rd = 21;
    instr2_valid = 1; instr2_p_rd = 60; instr2_old_p_rd = 61; instr2_arch_rd = 22;
    tick(); idle();
    checks++; if (next_robrow !== 6'd1) begin errors++; $display("FAIL wrap_robrow got %0d exp 1", next_robrow); end
    fu_done = 3'b111; fu_rob_tag[0] = 62; fu_rob_tag[1] = 63; fu_rob_tag[2] = 0;
    fu_result[0] = 32'hA; fu_result[1] = 32'hB; fu_result[2] = 32'hC;
    tick(); idle();
    tick();
`ifdef ROB_DUAL_RETIRE_EN
    checks++; if (commit_valid !== 2'b11 || commit_data[0] !== 32'hA || commit_data[1] !== 32'hB) begin errors++; $display("FAIL wrap_c1 got %b/%h/%h exp 11/a/b", commit_valid, commit_data[0], commit_data[1]); end
    checks++; if (commit_p_rd[1] !== 6'd50) begin errors++; $display("FAIL wrap_prd63 got %0d exp 50", commit_p_rd[1]); end
`else
    checks++; if (commit_valid !== 2'b01 || commit_data[0] !== 32'hA) begin errors++; $display("FAIL wrap_c1 got %b/%h exp 01/a", commit_valid, commit_data[0]); end
    tick();
    checks++; if (commit_valid !== 2'b01 || commit_data[0] !== 32'hB || commit_p_rd[0] !== 6'd50) begin errors++; $display("FAIL wrap_c2 got %b/%h/%0d exp 01/b/50", commit_valid, commit_data[0], commit_p_rd[0]); end
`endif
    tick();
    checks++; if (commit_valid !== 2'b01 || commit_data[0] !== 32'hC || commit_p_rd[0] !== 6'd60) begin errors++; $display("FAIL wrap_c3 got %b/%h/%0d exp 01/c/60", commit_valid, commit_data[0], commit_p_rd[0]); end
    tick();
    checks++; if (rob_empty !== 1'b1 || commit_valid !== 2'b00) begin errors++; $display("FAIL wrap_empty got %b/%b exp 1/00", rob_empty, commit_valid); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_data [6];
    int idx;
    do_reset();
    for (int i = 0; i < 6; i++) exp_data[i] = 32'h100 + i;
    for (int i = 0; i < 3; i++) begin
      disp2(6'(2 * i));
      tick();
    end
    idle();
    fu_done = 3'b111;
    fu_rob_tag[0] = 4;  fu_result[0] = 32'h104;
    fu_rob_tag[1] = 10; fu_result[1] = 32'hBAD;
    fu_rob_tag[2] = 5;  fu_result[2] = 32'h105;
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL same_nohead got %b exp 00", commit_valid); end
    fu_done = 3'b111;
    fu_rob_tag[0] = 0; fu_result[0] = 32'h100;
    fu_rob_tag[1] = 1; fu_result[1] = 32'h101;
    fu_rob_tag[2] = 2; fu_result[2] = 32'h102;
    tick(); idle();
    checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL same_wait got %b exp 00", commit_valid); end
    fu_done = 3'b001; fu_rob_tag[0] = 3; fu_result[0] = 32'h103;
    tick(); idle();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (commit_valid[s]) begin
          checks++;
          if (idx >= 6 || commit_data[s] !== exp_data[idx % 6]) begin
            errors++; $display("FAIL same_order idx %0d got %h exp %h", idx, commit_data[s], exp_data[idx % 6]);
          end
          idx++;
        end
      end
      tick();
    end
    checks++; if (idx != 6) begin errors++; $display("FAIL same_count got %0d exp 6", idx); end
    checks++; if (rob_empty !== 1'b1 || next_robrow !== 6'd6) begin errors++; $display("FAIL same_end got %b/%0d exp 1/6", rob_empty, next_robrow); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp2(6'(2 * i));
      tick();
    end
    idle();
    fu_done = 3'b001; fu_rob_tag[0] = 0; fu_result[0] = 32'h55;
    tick(); idle();
    tick();
    checks++; if (commit_valid !== 2'b01 || next_robrow !== 6'd10) begin errors++; $display("FAIL mid_pre got %b/%0d exp 01/10", commit_valid, next_robrow); end
    rst_n = 0;
    #1;
    checks++; if (commit_valid !== 2'b00 || commit_data !== 64'd0) begin errors++; $display("FAIL mid_commit got %b/%h exp 00/0", commit_valid, commit_data); end
    checks++; if (next_robrow !== 6'd0 || dispatch_stall !== 1'b0 || rob_empty !== 1'b1) begin errors++; $display("FAIL mid_state got %0d/%b/%b exp 0/0/1", next_robrow, dispatch_stall, rob_empty); end
    tick();
    rst_n = 1;
    repeat (3) tick();
    checks++; if (commit_valid !== 2'b00 || rob_empty !== 1'b1) begin errors++; $display("FAIL mid_after got %b/%b exp 00/1", commit_valid, rob_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_wrap();
    test_same_cycle();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
